// File: rtl/time_keeper_pkg.sv
// Shared types and limits for the time_keeper clock/display block.
package time_keeper_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_t;

  localparam int FIELD_W = 6;

  localparam logic [FIELD_W-1:0] MAX_SEC = 6'd59;
  localparam logic [FIELD_W-1:0] MAX_MIN = 6'd59;
  localparam logic [FIELD_W-1:0] MAX_HR  = 6'd23;

  // Modulo increment of a time field: max wraps back to zero.
  function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] value,
                                                  input logic [FIELD_W-1:0] max);
    return (value == max) ? '0 : value + FIELD_W'(1);
  endfunction

endpackage

// File: rtl/time_keeper_btn_edge.sv
// Button conditioner: 2-flop synchroniser followed by a registered
// rising-edge pulse. A warm-up shift register keeps the detector quiet
// until the history flop holds a real post-reset sample, so a button held
// through reset never produces a pulse.
module btn_edge (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  // sync[0], sync[1]: synchroniser; sync[2]: previous synchronised level
  logic [2:0] sync;
  logic [2:0] primed;

  // Synchronise, track history validity and emit a one-cycle pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync   <= '0;
      primed <= '0;
      pulse  <= 1'b0;
    end else begin
      sync   <= {sync[1:0], btn};
      primed <= {primed[1:0], 1'b1};
      pulse  <= sync[1] & ~sync[2] & primed[2];
    end
  end

endmodule

// File: rtl/time_keeper.sv
// time_keeper: 24-hour clock with set mode, 8-phase digit scan and
// optional set-mode blinking (enabled by defining TIME_KEEPER_BLINK_EN).
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int SEC_DIV  = 12000000,
  parameter int SCAN_DIV = 12000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        view_sel,
  output logic [11:0] data_show,
  output logic [2:0]  byte_status,
  output logic [3:0]  segment_byte_control,
  output logic [1:0]  mode
);

  localparam int PW = $clog2(SEC_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(SEC_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic               mode_p;
  logic               inc_p;
  logic               tick;
  logic [PW-1:0]      pre;
  logic [SW-1:0]      scan;
  mode_t              state;
  logic [FIELD_W-1:0] sec;
  logic [FIELD_W-1:0] min;
  logic [FIELD_W-1:0] hr;

  btn_edge u_mode_edge (
    .clock (clock),
    .reset (reset),
    .btn   (btn_mode),
    .pulse (mode_p)
  );

  btn_edge u_inc_edge (
    .clock (clock),
    .reset (reset),
    .btn   (btn_inc),
    .pulse (inc_p)
  );

  assign tick = (pre == PRE_LAST);
  assign mode = state;

  // Second prescaler; restarted on leaving set mode so the first second is full
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre <= '0;
    end else if (mode_p && (state == SET_MIN)) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // Mode FSM and time fields; a mode pulse takes priority over inc and tick
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      sec   <= '0;
      min   <= '0;
      hr    <= '0;
    end else if (mode_p) begin
      case (state)
        RUN: begin
          state <= SET_HR;
          sec   <= '0;
        end
        SET_HR:  state <= SET_MIN;
        default: state <= RUN;
      endcase
    end else if (state == RUN) begin
      if (tick) begin
        sec <= wrap_inc(sec, MAX_SEC);
        if (sec == MAX_SEC) begin
          min <= wrap_inc(min, MAX_MIN);
          if (min == MAX_MIN) begin
            hr <= wrap_inc(hr, MAX_HR);
          end
        end
      end
    end else if (inc_p) begin
      if (state == SET_HR) begin
        hr <= wrap_inc(hr, MAX_HR);
      end else begin
        min <= wrap_inc(min, MAX_MIN);
      end
    end
  end

  // Registered display word; set modes always show hours/minutes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_show <= '0;
    end else if (!view_sel || (state != RUN)) begin
      data_show <= {hr, min};
    end else begin
      data_show <= {min, sec};
    end
  end

  // Digit-scan phase, free running regardless of mode
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan        <= '0;
      byte_status <= '0;
    end else if (scan == SCAN_LAST) begin
      scan        <= '0;
      byte_status <= byte_status + 3'd1;
    end else begin
      scan <= scan + SW'(1);
    end
  end

`ifdef TIME_KEEPER_BLINK_EN
  localparam logic [PW-1:0] PRE_HALF = PW'(SEC_DIV / 2);

  // Blink the field being set during the second half of each second
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      segment_byte_control <= 4'b1111;
    end else if ((state == RUN) || (pre < PRE_HALF)) begin
      segment_byte_control <= 4'b1111;
    end else if (state == SET_HR) begin
      segment_byte_control <= 4'b0011;
    end else begin
      segment_byte_control <= 4'b1100;
    end
  end
`else
  assign segment_byte_control = 4'b1111;
`endif

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter SEC_DIV, default 12000000: clock cycles per second tick; legal values are 4 or more and even.
REQ-002 Parameter SCAN_DIV, default 12000: clock cycles per digit-scan step; legal values are 1 or more.
REQ-003 Port clock  in  1: the single clock; all state SHALL be on its rising edge.
REQ-004 Port reset  in  1: asynchronous, active-low reset.
REQ-005 Port btn_mode  in  1: asynchronous level input; each rising edge steps the mode.
REQ-006 Port btn_inc  in  1: asynchronous level input; each rising edge increments the field being set.
REQ-007 Port view_sel  in  1: 0 selects {hours, minutes}; 1 selects {minutes, seconds}.
REQ-008 Port data_show  out  12: [11:6] is the upper field and [5:0] is the lower field, both binary 0..59.
REQ-009 Port byte_status  out  3: digit-scan phase 0..7; even values drive digits 0..3, odd values are blanking gaps.
REQ-010 Port segment_byte_control  out  4: per-digit enable; 1 means lit; bit3:2 are the upper-field digits and bit1:0 the lower-field digits.
REQ-011 Port mode  out  2: current FSM state.

Function
REQ-012 Each button SHALL pass through a 2-flop synchroniser, then a rising-edge detector that gives a 1-cycle pulse, 3 cycles after the input edge.
REQ-013 The prescaler SHALL count 0..SEC_DIV-1, wrap to 0, and pulse tick in the cycle where the count equals SEC_DIV-1; it runs in all modes.
REQ-014 FSM states SHALL be RUN=0, SET_HR=1 and SET_MIN=2; the transitions on a mode pulse are RUN->SET_HR->SET_MIN->RUN.
REQ-015 On RUN->SET_HR, seconds SHALL clear to 0; on SET_MIN->RUN, the prescaler SHALL clear to 0.
REQ-016 In RUN, each tick SHALL do sec+1; 59 SHALL wrap to 0 and carry min+1; min 59 SHALL wrap to 0 and carry hr+1; hr 23 SHALL wrap to 0.
REQ-017 In SET_HR/SET_MIN, ticks SHALL NOT advance time; an inc pulse SHALL increment only the selected field (hr 23->0, min 59->0), with no carry.
REQ-018 If a mode pulse and an inc pulse occur in the same cycle, the mode pulse SHALL win and the inc pulse SHALL be dropped.
REQ-019 An inc pulse in RUN SHALL be ignored.
REQ-020 data_show SHALL be registered, with 1 cycle of latency after a field change.
REQ-021 data_show SHALL be {hr,min} when view_sel=0 or mode!=RUN, and {min,sec} otherwise.
REQ-022 byte_status SHALL increment every SCAN_DIV cycles and wrap 7->0, independent of mode.
REQ-023 Blink phase SHALL be "on" while prescaler < SEC_DIV/2, and "off" otherwise.
REQ-024 segment_byte_control SHALL be 4'b1111 in RUN and in any "on" phase.
REQ-025 In an "off" phase, segment_byte_control SHALL be 4'b0011 in SET_HR and 4'b1100 in SET_MIN.
REQ-026 segment_byte_control SHALL be registered.

Reset
REQ-027 Reset assertion SHALL asynchronously clear: prescaler, scan counter, sec, min, hr, synchroniser and edge flops.
REQ-028 Reset assertion SHALL also force data_show=0, byte_status=0, segment_byte_control=4'b1111 and mode=RUN.
REQ-029 Reset mid-set SHALL abandon the set and return to RUN at 00:00:00.
REQ-030 After release, no spurious button pulse SHALL occur even if a button is held high.

Configuration
REQ-031 With macro TIME_KEEPER_BLINK_EN defined, REQ-023..REQ-025 SHALL apply.
REQ-032 Without TIME_KEEPER_BLINK_EN, segment_byte_control SHALL be constant 4'b1111 and no blink logic SHALL be synthesised.

Structure
REQ-033 Package time_keeper_pkg SHALL hold the mode enum (RUN, SET_HR, SET_MIN), FIELD_W=6, MAX_SEC=59, MAX_MIN=59 and MAX_HR=23.
REQ-034 Sub-module btn_edge (synchroniser plus rising-edge pulse, clock/reset ports as above) SHALL be instantiated twice.

Verification
REQ-035 Rollover (bench SEC_DIV=4, SCAN_DIV=2): preload 23:59:59 in RUN, then 1 tick -> 00:00:00; with view_sel=0, data_show=0 on the next cycle.
REQ-036 Set sequence: mode pulse, then 25 inc pulses -> hr=1 (wrap at 23). Then mode pulse, then 3 inc pulses -> min+3 with no hr carry, sec=0. Then mode pulse -> mode=RUN, prescaler=0.
REQ-037 Simultaneous mode and inc edges in RUN -> mode=SET_HR, hr unchanged.
REQ-038 Blink (BLINK_EN defined, SET_MIN, SEC_DIV=4) -> segment_byte_control alternates 4'b1111 for 2 cycles and 4'b1100 for 2 cycles.
REQ-039 Scan: byte_status sequence is 0,0,1,1,...,7,7,0 with SCAN_DIV=2.
REQ-040 Reset asserted mid-SET_HR with btn_mode held high -> after release, mode stays RUN, 00:00:00, and no pulse is seen.
